// File: rtl/pc_predictor.sv
// pc_predictor: direct-mapped branch target table with 2-bit counters,
// EX-resolved redirect generation and saturating performance counters.
module pc_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  if_pc,
  output logic             pred_taken,
  output logic [XLEN-1:0]  pred_target,
  input  logic             ex_valid,
  input  logic             ex_stall,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic             ex_is_branch,
  input  logic             ex_is_jump,
  input  logic             ex_taken,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             ex_pred_taken,
  input  logic [XLEN-1:0]  ex_pred_target,
  input  logic             trap_valid,
  input  logic [XLEN-1:0]  trap_pc,
  output logic             redirect,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] miss_cnt
);
  localparam int IDX_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tags    [ENTRIES];
  logic [XLEN-1:0]    targets [ENTRIES];
  logic [1:0]         ctrs    [ENTRIES];

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             if_hit, ex_hit, act, upd, trap_go, mispredict;
  logic [XLEN-1:0]  correct_next;
  logic [1:0]       ctr_q;

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[IDX_W+TAG_W+1:IDX_W+2];

  assign if_hit      = valid[if_idx] && tags[if_idx] == if_tag;
  assign pred_taken  = if_hit & ctrs[if_idx][1];
  assign pred_target = pred_taken ? targets[if_idx] : if_pc + XLEN'(4);

  assign act          = ex_valid & ~ex_stall & (ex_is_branch | ex_is_jump);
  assign upd          = act & ~trap_valid;
  assign trap_go      = trap_valid & ~ex_stall;
  assign correct_next = ex_taken ? ex_target : ex_pc + XLEN'(4);
  assign mispredict   = act & ((ex_pred_taken != ex_taken) | (ex_pred_target != correct_next));
  assign ex_hit       = valid[ex_idx] && tags[ex_idx] == ex_tag;
  assign ctr_q        = ctrs[ex_idx];

  // Gated by rst_n so the flush request drops the moment reset asserts.
  assign redirect    = rst_n & (trap_go | mispredict);
  assign redirect_pc = !rst_n ? '0 : trap_go ? trap_pc : mispredict ? correct_next : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tags[i]    <= '0;
        targets[i] <= '0;
        ctrs[i]    <= 2'b01;
      end
    end else if (upd) begin
      if (ex_hit && ex_is_jump) begin
        ctrs[ex_idx]    <= 2'b11;
        targets[ex_idx] <= ex_target;
      end else if (ex_hit) begin
        ctrs[ex_idx] <= ex_taken ? (ctr_q == 2'b11 ? ctr_q : ctr_q + 2'b01)
                                 : (ctr_q == 2'b00 ? ctr_q : ctr_q - 2'b01);
        if (ex_taken) targets[ex_idx] <= ex_target;
      end else if (ex_taken) begin
        valid[ex_idx]   <= 1'b1;
        tags[ex_idx]    <= ex_tag;
        targets[ex_idx] <= ex_target;
        ctrs[ex_idx]    <= ex_is_jump ? 2'b11 : 2'b10;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt   <= '0;
      miss_cnt <= '0;
    end else begin
      if (upd && br_cnt != '1) br_cnt <= br_cnt + CNT_W'(1);
      if (mispredict && !trap_valid && miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pc_predictor.sv
// tb_pc_predictor: directed and random checks of pc_predictor against an
// array-based reference model of the prediction table.
module tb_pc_predictor;
  localparam int CNT_W = 4;
  localparam int CMAX  = 15;

  logic        clk = 0, rst_n = 0;
  logic [31:0] if_pc = 0, ex_pc = 0, ex_target = 0, ex_pred_target = 0, trap_pc = 0;
  logic        ex_valid = 0, ex_stall = 0, ex_is_branch = 0, ex_is_jump = 0;
  logic        ex_taken = 0, ex_pred_taken = 0, trap_valid = 0;
  logic        pred_taken, redirect;
  logic [31:0] pred_target, redirect_pc;
  logic [CNT_W-1:0] br_cnt, miss_cnt;

  pc_predictor #(.XLEN(32), .ENTRIES(16), .TAG_W(8), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .pred_taken(pred_taken),
    .pred_target(pred_target), .ex_valid(ex_valid), .ex_stall(ex_stall),
    .ex_pc(ex_pc), .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump),
    .ex_taken(ex_taken), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .trap_valid(trap_valid), .trap_pc(trap_pc),
    .redirect(redirect), .redirect_pc(redirect_pc), .br_cnt(br_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one record per table slot, counters as plain ints.
  bit          mv   [16];
  int          mtag [16];
  logic [31:0] mtgt [16];
  int          mctr [16];
  int          mbr, mmiss;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % 16);
  endfunction

  function automatic int tag_of(input logic [31:0] pc);
    return int'((pc >> 6) % 256);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      mv[i] = 0; mtag[i] = 0; mtgt[i] = 0; mctr[i] = 1;
    end
    mbr = 0; mmiss = 0;
  endtask

  task automatic set_ex(input bit v, input bit br, input bit jp, input logic [31:0] pc,
                        input bit tk, input logic [31:0] tg, input bit pt, input logic [31:0] ptg);
    ex_valid = v; ex_is_branch = br; ex_is_jump = jp; ex_pc = pc;
    ex_taken = tk; ex_target = tg; ex_pred_taken = pt; ex_pred_target = ptg;
  endtask

  // Checks lookup/redirect before the edge, then counters after it.
  task automatic cycle();
    int i, e;
    bit hit, pt, act, mis, te, ehit;
    logic [31:0] cn;
    #2;
    i   = idx_of(if_pc);
    hit = mv[i] && mtag[i] == tag_of(if_pc);
    pt  = hit && mctr[i] >= 2;
    chk("pred_taken", 32'(pred_taken), 32'(pt));
    chk("pred_target", pred_target, pt ? mtgt[i] : if_pc + 4);
    act = ex_valid && !ex_stall && (ex_is_branch || ex_is_jump);
    cn  = ex_taken ? ex_target : ex_pc + 4;
    mis = act && (ex_pred_taken != ex_taken || ex_pred_target != cn);
    te  = trap_valid && !ex_stall;
    chk("redirect", 32'(redirect), 32'(te || mis));
    chk("redirect_pc", redirect_pc, te ? trap_pc : mis ? cn : 32'h0);
    @(posedge clk);
    #1;
    if (act && !trap_valid) begin
      e = idx_of(ex_pc);
      ehit = mv[e] && mtag[e] == tag_of(ex_pc);
      if (ehit && ex_is_jump) begin
        mctr[e] = 3; mtgt[e] = ex_target;
      end else if (ehit) begin
        mctr[e] = ex_taken ? (mctr[e] < 3 ? mctr[e] + 1 : 3) : (mctr[e] > 0 ? mctr[e] - 1 : 0);
        if (ex_taken) mtgt[e] = ex_target;
      end else if (ex_taken) begin
        mv[e] = 1; mtag[e] = tag_of(ex_pc); mtgt[e] = ex_target; mctr[e] = ex_is_jump ? 3 : 2;
      end
      if (mbr < CMAX) mbr++;
      if (mis && mmiss < CMAX) mmiss++;
    end
    chk("br_cnt", 32'(br_cnt), 32'(mbr));
    chk("miss_cnt", 32'(miss_cnt), 32'(mmiss));
  endtask

  task automatic idle_lookup(input logic [31:0] pc);
    set_ex(0, 0, 0, 0, 0, 0, 0, 0);
    if_pc = pc;
    cycle();
  endtask

  initial begin
    logic [31:0] pc, tg, cn;
    bit tk, jp;
    model_reset();
    if_pc = 32'h100; trap_valid = 1; trap_pc = 32'h8000;
    #3;
    chk("rst_pred_taken", 32'(pred_taken), 0);
    chk("rst_pred_target", pred_target, 32'h104);
    chk("rst_redirect", 32'(redirect), 0);
    chk("rst_br_cnt", 32'(br_cnt), 0);
    chk("rst_miss_cnt", 32'(miss_cnt), 0);
    trap_valid = 0;
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;

    // Taken BEQ, initially predicted not-taken
    if_pc = 32'h100;
    set_ex(1, 1, 0, 32'h100, 1, 32'h80, 0, 32'h104);
    #1 chk("beq_redirect_pc", redirect_pc, 32'h80);
    cycle();
    chk("beq_miss_cnt", 32'(miss_cnt), 1);
    set_ex(0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("beq_pred_taken", 32'(pred_taken), 1);
    chk("beq_pred_target", pred_target, 32'h80);
    cycle();

    // Not-taken three times: 10 -> 01 -> 00 -> 00
    set_ex(1, 1, 0, 32'h100, 0, 32'h80, 1, 32'h80);
    #1 chk("nt1_redirect_pc", redirect_pc, 32'h104);
    cycle();
    for (int k = 0; k < 2; k++) begin
      set_ex(1, 1, 0, 32'h100, 0, 32'h80, 0, 32'h104);
      #1 chk("nt_redirect", 32'(redirect), 0);
      cycle();
    end
    set_ex(0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("nt_pred_taken", 32'(pred_taken), 0);
    cycle();
    // one taken from 00 only reaches 01: still predicted not-taken
    set_ex(1, 1, 0, 32'h100, 1, 32'h80, 0, 32'h104);
    cycle();
    idle_lookup(32'h100);

    // JALR: allocate to 0x300, then resolved to 0x340
    set_ex(1, 0, 1, 32'h200, 1, 32'h300, 1, 32'h204);
    cycle();
    set_ex(1, 0, 1, 32'h200, 1, 32'h340, 1, 32'h300);
    if_pc = 32'h200;
    #1 chk("jalr_redirect_pc", redirect_pc, 32'h340);
    cycle();
    set_ex(0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("jalr_pred_target", pred_target, 32'h340);
    cycle();

    // Alias: 0x1100 and 0x100 share index 0 with different tags
    set_ex(1, 1, 0, 32'h1100, 1, 32'h2000, 0, 32'h1104);
    cycle();
    set_ex(0, 0, 0, 0, 0, 0, 0, 0);
    if_pc = 32'h100;
    #1 chk("alias_miss", 32'(pred_taken), 0);
    cycle();
    set_ex(1, 1, 0, 32'h100, 1, 32'h90, 0, 32'h104);
    cycle();
    idle_lookup(32'h100);
    idle_lookup(32'h1100);

    // Trap beside a mispredicted branch, then the same under stall
    set_ex(1, 1, 0, 32'h300, 1, 32'h500, 0, 32'h304);
    trap_valid = 1; trap_pc = 32'h8000; if_pc = 32'h300;
    #1 chk("trap_redirect_pc", redirect_pc, 32'h8000);
    cycle();
    ex_stall = 1;
    #1 chk("stall_redirect", 32'(redirect), 0);
    cycle();
    trap_valid = 0; ex_stall = 0;
    idle_lookup(32'h300);

    // Random phase: small PC pool to force hits and aliases
    for (int n = 0; n < 400; n++) begin
      pc = 32'h100 + ($urandom_range(0, 3) << 6) + ($urandom_range(0, 7) << 2) + ($urandom_range(0, 1) << 12);
      jp = $urandom_range(0, 3) == 0;
      tk = jp || $urandom_range(0, 1);
      tg = 32'h4000 + ($urandom_range(0, 3) << 4);
      cn = tk ? tg : pc + 4;
      set_ex($urandom_range(0, 5) != 0, !jp || $urandom_range(0, 7) == 0, jp, pc, tk, tg,
             $urandom_range(0, 1), $urandom_range(0, 2) != 0 ? cn : tg + 8);
      ex_stall   = $urandom_range(0, 7) == 0;
      trap_valid = $urandom_range(0, 9) == 0;
      trap_pc    = $urandom;
      if_pc      = 32'h100 + ($urandom_range(0, 3) << 6) + ($urandom_range(0, 7) << 2) + ($urandom_range(0, 1) << 12);
      cycle();
    end
    chk("br_cnt_sat", 32'(br_cnt), 32'(CMAX));

    // Asynchronous reset mid-operation
    set_ex(1, 1, 0, 32'h100, 1, 32'h80, 0, 32'h104);
    trap_valid = 1; ex_stall = 0;
    #2 rst_n = 0;
    #1 chk("arst_redirect", 32'(redirect), 0);
    chk("arst_br_cnt", 32'(br_cnt), 0);
    chk("arst_pred_taken", 32'(pred_taken), 0);
    model_reset();
    set_ex(0, 0, 0, 0, 0, 0, 0, 0);
    trap_valid = 0;
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    for (int n = 0; n < 40; n++) begin
      pc = 32'h100 + ($urandom_range(0, 7) << 2);
      tk = $urandom_range(0, 1);
      set_ex(1, 1, 0, pc, tk, 32'h600, $urandom_range(0, 1), tk ? 32'h600 : pc + 4);
      if_pc = 32'h100 + ($urandom_range(0, 7) << 2);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pc_predictor.md
Name: pc_predictor

Overview:
Parametrised next-PC predictor. It replaces the purely combinational, EX-resolved PC selection with a direct-mapped branch target table: 2-bit saturating counters, tags and targets. The IF stage looks up the current PC combinationally and gets a predicted next PC. The EX stage reports resolved branch, jump and trap outcomes; the block trains the table, raises a redirect on misprediction or trap, and keeps saturating performance counters.

Parameters:
XLEN, 32, PC/target width
ENTRIES, 16, table depth; power of two, ≥2
TAG_W, 8, tag bits stored per entry
CNT_W, 32, performance counter width

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
if_pc  input  XLEN  fetch PC for lookup
pred_taken  output  1  predicted taken for if_pc
pred_target  output  XLEN  predicted next PC (if_pc+4 when not taken)
ex_valid  input  1  EX stage holds a valid instruction
ex_stall  input  1  EX frozen; suppresses update, redirect and counting
ex_pc  input  XLEN  PC of EX instruction
ex_is_branch  input  1  conditional branch
ex_is_jump  input  1  JAL/JALR
ex_taken  input  1  resolved direction (1 for jumps)
ex_target  input  XLEN  resolved target
ex_pred_taken  input  1  prediction carried down the pipe with the instruction
ex_pred_target  input  XLEN  predicted next PC carried down the pipe
trap_valid  input  1  interrupt taken or mret in EX
trap_pc  input  XLEN  ISR entry or mepc
redirect  output  1  flush front end, fetch redirect_pc
redirect_pc  output  XLEN  correct next PC
br_cnt  output  CNT_W  resolved control-flow instructions
miss_cnt  output  CNT_W  mispredictions

Behaviour:
- Fields: IDX_W = log2(ENTRIES). idx = pc[IDX_W+1:2]. tag = pc[IDX_W+TAG_W+1:IDX_W+2]. pc[1:0] ignored.
- Entry layout: valid, tag[TAG_W], target[XLEN], ctr[2].
- Reset (async, rst_n=0):
  - all valid=0, all ctr=2'b01;
  - br_cnt=0, miss_cnt=0, redirect=0, redirect_pc=0;
  - pred_taken=0, pred_target=if_pc+4 (combinational).
- Lookup (combinational, zero latency):
  - hit = valid & tag match.
  - pred_taken = hit & ctr[1].
  - pred_target = pred_taken ? target : if_pc+4.
- Resolve (combinational), act = ex_valid & ~ex_stall & (ex_is_branch | ex_is_jump):
  - correct_next = ex_taken ? ex_target : ex_pc+4.
  - mispredict = act & (ex_pred_taken != ex_taken, or ex_pred_target != correct_next).
- Redirect priority, highest first:
  1. trap_valid & ~ex_stall: redirect=1, redirect_pc=trap_pc; no table update, no counting that cycle.
  2. mispredict: redirect=1, redirect_pc=correct_next.
  3. Otherwise redirect=0, redirect_pc=0.
- Table update (posedge clk, only when act & ~trap_valid):
  - Hit, branch: ctr saturating increment if taken, decrement if not (0..3); target overwritten with ex_target when taken.
  - Hit, jump: ctr=2'b11, target=ex_target.
  - Miss, taken: allocate (replace) with valid=1, tag, target=ex_target; ctr=2'b11 for jump, 2'b10 for branch.
  - Miss, not-taken branch: no allocation.
- Same-cycle lookup and update to the same index: lookup returns the pre-update entry; no bypass.
- Counters:
  - br_cnt increments when act & ~trap_valid.
  - miss_cnt increments when mispredict & ~trap_valid.
  - Both saturate at all-ones, never wrap.
- ex_is_branch and ex_is_jump both set is illegal: treat as jump.
- Reset mid-operation clears all state immediately; redirect deasserts asynchronously.

Test Plan:
- After reset, if_pc=0x100 → pred_taken=0, pred_target=0x104; any idx gives br_cnt=0, miss_cnt=0.
- Taken BEQ at ex_pc=0x100, target 0x80, pred_taken=0 → redirect=1, redirect_pc=0x80, miss_cnt=1. Next cycle if_pc=0x100 → pred_taken=1 (ctr=10), pred_target=0x80.
- Same branch resolved not-taken three times → ctr 10→01→00→00, saturating at 00. First resolve mispredicts (redirect_pc=0x104); later ones do not; lookup pred_taken=0.
- JALR at 0x200 predicted 0x300, resolved 0x340 → redirect_pc=0x340, entry target updated, ctr=11.
- Alias: with ENTRIES=16, a taken branch at 0x1100 is allocated, then lookup at 0x100 (same idx, different tag) → pred_taken=0. The later taken branch at 0x100 then replaces the entry.
- trap_valid with trap_pc=0x8000 alongside a mispredicted branch → redirect_pc=0x8000, table unchanged, counters unchanged. Repeat with ex_stall=1 → redirect=0, nothing changes.
